// File: rtl/hazard_stall_controller.sv
// Hazard controller for the five-stage pipeline: load-use and HiLo stalls,
// branch/jump squashing, mult/div occupancy tracking and a stall-cycle counter.
module hazard_stall_controller #(
    parameter int MULDIV_CYCLES = 4,
    parameter int STALL_CNT_W   = 16
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [4:0]             IDRs,
    input  logic [4:0]             IDRt,
    input  logic                   IDUsesRt,
    input  logic                   IDMulDiv,
    input  logic                   IDUsesHiLo,
    input  logic                   IDJump,
    input  logic                   EXMemRead,
    input  logic [4:0]             EXRt,
    input  logic                   EXBranchTaken,
    output logic                   PCWrite,
    output logic                   IFIDWrite,
    output logic                   IFIDFlush,
    output logic                   IDEXFlush,
    output logic                   MulDivBusy,
    output logic [STALL_CNT_W-1:0] StallCycles
);

    typedef enum logic [1:0] {
        CTRL_RUN,
        CTRL_JUMP,
        CTRL_STALL,
        CTRL_BRANCH
    } ctrl_e;

    localparam logic [3:0] BUSY_LOAD = 4'(MULDIV_CYCLES);

    logic [3:0]             r_busy_cnt;
    logic [STALL_CNT_W-1:0] r_stall_cycles;
    logic                   w_busy;
    logic                   w_load_use;
    logic                   w_hilo_stall;
    logic                   w_issue;
    ctrl_e                  w_ctrl;

    assign w_busy       = (r_busy_cnt != 4'd0);
    assign w_load_use   = EXMemRead && (EXRt != 5'd0) &&
                          ((EXRt == IDRs) || (IDUsesRt && (EXRt == IDRt)));
    assign w_hilo_stall = w_busy && (IDUsesHiLo || IDMulDiv);

    // A taken branch outranks every stall; a stalled jump is retried once the stall clears.
    always_comb begin
        w_ctrl = CTRL_RUN;
        if (EXBranchTaken) begin
            w_ctrl = CTRL_BRANCH;
        end else if (w_load_use || w_hilo_stall) begin
            w_ctrl = CTRL_STALL;
        end else if (IDJump) begin
            w_ctrl = CTRL_JUMP;
        end
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        PCWrite   = 1'b1;
        IFIDWrite = 1'b1;
        IFIDFlush = 1'b0;
        IDEXFlush = 1'b0;
        case (w_ctrl)
            CTRL_BRANCH: begin
                IFIDFlush = 1'b1;
                IDEXFlush = 1'b1;
            end
            CTRL_STALL: begin
                PCWrite   = 1'b0;
                IFIDWrite = 1'b0;
                IDEXFlush = 1'b1;
            end
            CTRL_JUMP: begin
                IFIDFlush = 1'b1;
            end
            default: ;
        endcase
        // Hold the pipeline flushed for as long as reset is asserted.
        if (!Rst_n) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IFIDFlush = 1'b1;
            IDEXFlush = 1'b1;
        end
    end

    assign w_issue     = IDMulDiv && (w_ctrl != CTRL_BRANCH) && (w_ctrl != CTRL_STALL);
    assign MulDivBusy  = w_busy;
    assign StallCycles = r_stall_cycles;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_busy_cnt <= 4'd0;
        end else if (w_issue) begin
            r_busy_cnt <= BUSY_LOAD;
        end else if (w_busy) begin
            r_busy_cnt <= r_busy_cnt - 4'd1;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_stall_cycles <= '0;
        end else if (!PCWrite && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + STALL_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench: directed scenarios plus random stimulus, compared every
// cycle against a cycle-count based reference model of the hazard rules.
module tb_hazard_stall_controller;

    localparam int MULDIV_N = 4;

    logic        Clk;
    logic        Rst_n;
    logic [4:0]  IDRs, IDRt, EXRt;
    logic        IDUsesRt, IDMulDiv, IDUsesHiLo, IDJump, EXMemRead, EXBranchTaken;
    logic        PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, MulDivBusy;
    logic        PCWrite4, IFIDWrite4, IFIDFlush4, IDEXFlush4, MulDivBusy4;
    logic [15:0] StallCycles;
    logic [3:0]  StallCycles4;

    hazard_stall_controller #(.MULDIV_CYCLES(MULDIV_N), .STALL_CNT_W(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
        .IDMulDiv(IDMulDiv), .IDUsesHiLo(IDUsesHiLo), .IDJump(IDJump),
        .EXMemRead(EXMemRead), .EXRt(EXRt), .EXBranchTaken(EXBranchTaken),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IFIDFlush(IFIDFlush),
        .IDEXFlush(IDEXFlush), .MulDivBusy(MulDivBusy), .StallCycles(StallCycles)
    );

    hazard_stall_controller #(.MULDIV_CYCLES(MULDIV_N), .STALL_CNT_W(4)) dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .IDRs(IDRs), .IDRt(IDRt), .IDUsesRt(IDUsesRt),
        .IDMulDiv(IDMulDiv), .IDUsesHiLo(IDUsesHiLo), .IDJump(IDJump),
        .EXMemRead(EXMemRead), .EXRt(EXRt), .EXBranchTaken(EXBranchTaken),
        .PCWrite(PCWrite4), .IFIDWrite(IFIDWrite4), .IFIDFlush(IFIDFlush4),
        .IDEXFlush(IDEXFlush4), .MulDivBusy(MulDivBusy4), .StallCycles(StallCycles4)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: cycle number, last busy cycle of the mult/div unit, and
    // an unbounded stall total that each counter width saturates on its own.
    int cyc         = 0;
    int busy_until  = -1;
    int stall_total = 0;

    logic e_busy, e_lu, e_hs, e_issue, e_pc, e_ifidw, e_ifidf, e_idexf;

    always_comb begin
        e_busy  = 1'b0;
        e_lu    = 1'b0;
        e_hs    = 1'b0;
        e_issue = 1'b0;
        e_pc    = 1'b1;
        e_ifidw = 1'b1;
        e_ifidf = 1'b0;
        e_idexf = 1'b0;
        e_busy  = Rst_n && (busy_until >= cyc);
        e_lu    = EXMemRead && (EXRt != 5'd0) &&
                  ((EXRt == IDRs) || (IDUsesRt && (EXRt == IDRt)));
        e_hs    = e_busy && (IDUsesHiLo || IDMulDiv);
        e_issue = IDMulDiv && !EXBranchTaken && !e_lu && !e_hs;
        if (!Rst_n) begin
            e_pc = 1'b0; e_ifidw = 1'b0; e_ifidf = 1'b1; e_idexf = 1'b1;
        end else if (EXBranchTaken) begin
            e_ifidf = 1'b1; e_idexf = 1'b1;
        end else if (e_lu || e_hs) begin
            e_pc = 1'b0; e_ifidw = 1'b0; e_idexf = 1'b1;
        end else if (IDJump) begin
            e_ifidf = 1'b1;
        end
    end

    always @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            busy_until  <= -1;
            stall_total <= 0;
        end else begin
            stall_total <= stall_total + (e_pc ? 0 : 1);
            cyc         <= cyc + 1;
            if (e_issue) busy_until <= cyc + MULDIV_N;
        end
    end

    function automatic int sat(input int total, input int w);
        int top;
        top = (1 << w) - 1;
        return (total > top) ? top : total;
    endfunction

    // Hand-computed expectations queued by the stimulus process, checked by the compare process.
    typedef struct {
        string name;
        int    sel;
        int    val;
        int    act;
    } pin_t;

    pin_t pins[128];
    int   pin_wr = 0;
    int   pin_rd = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic pin(input string name, input int sel, input int val, input int act = 0);
        if (pin_wr < 128) begin
            pins[pin_wr] = '{name, sel, val, act};
            pin_wr++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        check("PCWrite", int'(PCWrite), int'(e_pc));
        check("IFIDWrite", int'(IFIDWrite), int'(e_ifidw));
        check("IFIDFlush", int'(IFIDFlush), int'(e_ifidf));
        check("IDEXFlush", int'(IDEXFlush), int'(e_idexf));
        check("MulDivBusy", int'(MulDivBusy), int'(e_busy));
        check("StallCycles16", int'(StallCycles), sat(stall_total, 16));
        check("StallCycles4", int'(StallCycles4), sat(stall_total, 4));
        check("PCWrite_w4", int'(PCWrite4), int'(e_pc));
        while (pin_rd < pin_wr) begin
            case (pins[pin_rd].sel)
                0:       check(pins[pin_rd].name, int'(PCWrite), pins[pin_rd].val);
                1:       check(pins[pin_rd].name, int'(IFIDWrite), pins[pin_rd].val);
                2:       check(pins[pin_rd].name, int'(IFIDFlush), pins[pin_rd].val);
                3:       check(pins[pin_rd].name, int'(IDEXFlush), pins[pin_rd].val);
                4:       check(pins[pin_rd].name, int'(MulDivBusy), pins[pin_rd].val);
                5:       check(pins[pin_rd].name, int'(StallCycles), pins[pin_rd].val);
                6:       check(pins[pin_rd].name, int'(StallCycles4), pins[pin_rd].val);
                default: check(pins[pin_rd].name, pins[pin_rd].act, pins[pin_rd].val);
            endcase
            pin_rd++;
        end
    end

    task automatic clear_inputs();
        IDRs = 5'd0; IDRt = 5'd0; EXRt = 5'd0;
        IDUsesRt = 1'b0; IDMulDiv = 1'b0; IDUsesHiLo = 1'b0;
        IDJump = 1'b0; EXMemRead = 1'b0; EXBranchTaken = 1'b0;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Counts consecutive stall cycles with the current inputs held, bounded at 20.
    task automatic count_stall(output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (PCWrite) break;
            n++;
            if (MulDivBusy) nbusy++;
            @(posedge Clk);
            #1;
        end
    endtask

    int n_stall, n_busy;

    initial begin
        Rst_n = 1'b0;
        clear_inputs();
        @(posedge Clk);
        #1;
        pin("rst_pcwrite", 0, 0);
        pin("rst_ifidwrite", 1, 0);
        pin("rst_ifidflush", 2, 1);
        pin("rst_idexflush", 3, 1);
        pin("rst_busy", 4, 0);
        pin("rst_stall", 5, 0);
        tick();
        Rst_n = 1'b1;
        tick();

        // Load-use on rs stalls one cycle.
        EXMemRead = 1'b1; EXRt = 5'd5; IDRs = 5'd5;
        pin("lu_pcwrite", 0, 0);
        pin("lu_ifidwrite", 1, 0);
        pin("lu_idexflush", 3, 1);
        pin("lu_ifidflush", 2, 0);
        tick();
        clear_inputs();
        pin("lu_count", 5, 1);
        pin("lu_released", 0, 1);
        tick();

        // rt match without IDUsesRt is not a hazard.
        EXMemRead = 1'b1; EXRt = 5'd5; IDRs = 5'd3; IDRt = 5'd5; IDUsesRt = 1'b0;
        pin("rt_unused_pcwrite", 0, 1);
        tick();
        clear_inputs();
        pin("rt_unused_count", 5, 1);
        tick();

        // Register zero never stalls.
        EXMemRead = 1'b1; EXRt = 5'd0; IDRs = 5'd0; IDRt = 5'd0; IDUsesRt = 1'b1;
        pin("r0_pcwrite", 0, 1);
        pin("r0_idexflush", 3, 0);
        tick();
        clear_inputs();
        pin("r0_count", 5, 1);
        tick();

        // Mult/div followed by a HiLo reader.
        IDMulDiv = 1'b1;
        pin("md_issue_busy", 4, 0);
        tick();
        IDMulDiv = 1'b0; IDUsesHiLo = 1'b1;
        pin("md_busy_after_issue", 4, 1);
        count_stall(n_stall, n_busy);
        pin("hilo_stall_len", 7, 4, n_stall);
        pin("hilo_busy_len", 7, 4, n_busy);
        tick();
        clear_inputs();

        // Back-to-back mult/div.
        IDMulDiv = 1'b1;
        tick();
        count_stall(n_stall, n_busy);
        pin("b2b_stall_len", 7, 4, n_stall);
        tick();
        clear_inputs();
        repeat (5) tick();
        pin("b2b_drained", 4, 0);
        tick();

        // Branch overrides load-use and blocks mult/div issue.
        EXBranchTaken = 1'b1; EXMemRead = 1'b1; EXRt = 5'd5; IDRs = 5'd5; IDMulDiv = 1'b1;
        pin("br_ifidflush", 2, 1);
        pin("br_idexflush", 3, 1);
        pin("br_pcwrite", 0, 1);
        pin("br_ifidwrite", 1, 1);
        tick();
        clear_inputs();
        pin("br_no_issue", 4, 0);
        tick();

        // Branch does not clear an outstanding mult/div.
        IDMulDiv = 1'b1;
        tick();
        clear_inputs();
        tick();
        tick();
        EXBranchTaken = 1'b1;
        pin("br_busy2", 4, 1);
        tick();
        clear_inputs();
        pin("br_busy1", 4, 1);
        tick();
        pin("br_busy0", 4, 0);
        tick();

        // Jump waits behind a load-use stall.
        IDJump = 1'b1; EXMemRead = 1'b1; EXRt = 5'd7; IDRs = 5'd7;
        pin("jmp_stall_ifidflush", 2, 0);
        pin("jmp_stall_pcwrite", 0, 0);
        tick();
        EXMemRead = 1'b0;
        pin("jmp_go_ifidflush", 2, 1);
        pin("jmp_go_pcwrite", 0, 1);
        pin("jmp_go_idexflush", 3, 0);
        tick();
        clear_inputs();

        // Twenty forced stalls saturate the 4-bit counter.
        EXMemRead = 1'b1; EXRt = 5'd9; IDRs = 5'd9;
        repeat (20) tick();
        clear_inputs();
        pin("sat_w4", 6, 15);
        pin("sat_w16", 5, 30);
        tick();

        // Reset in the middle of a busy window.
        IDMulDiv = 1'b1;
        tick();
        clear_inputs();
        tick();
        Rst_n = 1'b0;
        pin("midrst_busy", 4, 0);
        pin("midrst_stall16", 5, 0);
        pin("midrst_stall4", 6, 0);
        pin("midrst_ifidflush", 2, 1);
        pin("midrst_idexflush", 3, 1);
        pin("midrst_pcwrite", 0, 0);
        tick();
        Rst_n = 1'b1;
        pin("postrst_pcwrite", 0, 1);
        tick();

        // Random traffic with a small register window to make hazards frequent.
        for (int i = 0; i < 3000; i++) begin
            Rst_n         = ($urandom_range(0, 199) != 0);
            EXMemRead     = ($urandom_range(0, 2) == 0);
            EXRt          = 5'($urandom_range(0, 3));
            IDRs          = 5'($urandom_range(0, 3));
            IDRt          = 5'($urandom_range(0, 3));
            IDUsesRt      = ($urandom_range(0, 1) == 0);
            IDMulDiv      = ($urandom_range(0, 5) == 0);
            IDUsesHiLo    = ($urandom_range(0, 4) == 0);
            IDJump        = ($urandom_range(0, 5) == 0);
            EXBranchTaken = ($urandom_range(0, 7) == 0);
            tick();
        end

        Rst_n = 1'b1;
        clear_inputs();
        tick();
        @(negedge Clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
